// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and frame-check helper for the PS/2 receive path.
package ps2_pkg;

  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam int unsigned PS2_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Odd parity over data+parity, and stop bit must be high.
  function automatic logic ps2_frame_ok(input logic [7:0] data,
                                        input logic       parity,
                                        input logic       stop);
    return stop & ((^data) ^ parity);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises raw PS/2 lines and debounces ps2_clk; emits a falling-edge pulse
// aligned with the synchronised data bit to be sampled.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_edge
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic             clk_meta_q,  clk_sync_q;
  logic             data_meta_q, data_sync_q;
  logic             filt_q,      filt_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             fall_edge_q, fall_edge_d;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d      = filt_q;
    cnt_d       = '0;
    fall_edge_d = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d      = clk_sync_q;
        fall_edge_d = filt_q & ~clk_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_edge_q <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_edge_q <= fall_edge_d;
    end
  end

  assign data_sync = data_sync_q;
  assign fall_edge = fall_edge_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, folds F0/E0
// prefixes into flags and emits one scan-code event per key action.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       is_break_code,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned WDOG_W    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BIT_CNT_W = $clog2(PS2_DATA_BITS);

  logic data_sync;
  logic fall_edge;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall_edge (fall_edge)
  );

  ps2_state_e           state_q,      state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [7:0]           shift_q,      shift_d;
  logic                 parity_q,     parity_d;
  logic                 brk_pend_q,   brk_pend_d;
  logic                 ext_pend_q,   ext_pend_d;
  logic [7:0]           scan_code_q,  scan_code_d;
  logic                 is_break_q,   is_break_d;
  logic                 is_ext_q,     is_ext_d;
  logic                 code_valid_q, code_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic [WDOG_W-1:0]    wdog_q,       wdog_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      brk_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      scan_code_q  <= '0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      brk_pend_q   <= brk_pend_d;
      ext_pend_q   <= ext_pend_d;
      scan_code_q  <= scan_code_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      wdog_q       <= wdog_d;
    end
  end

  // Next-state, frame evaluation, prefix tracking and mid-frame watchdog.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    brk_pend_d   = brk_pend_q;
    ext_pend_d   = ext_pend_q;
    scan_code_d  = scan_code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    wdog_d       = '0;

    case (state_q)
      IDLE: begin
        if (fall_edge && !data_sync) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_edge) begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_edge) begin
          parity_d = data_sync;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_edge) begin
          state_d = IDLE;
          if (!ps2_frame_ok(shift_q, parity_q, data_sync)) begin
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
            ext_pend_d  = 1'b0;
          end else if (shift_q == PS2_BREAK_PREFIX) begin
            brk_pend_d = 1'b1;
          end else if (shift_q == PS2_EXT_PREFIX) begin
            ext_pend_d = 1'b1;
          end else begin
            scan_code_d  = shift_q;
            is_break_d   = brk_pend_q;
            is_ext_d     = ext_pend_q;
            code_valid_d = 1'b1;
            brk_pend_d   = 1'b0;
            ext_pend_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog runs only mid-frame; any accepted edge reloads it via the default.
    if (state_q != IDLE && !fall_edge) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
        brk_pend_d  = 1'b0;
        ext_pend_d  = 1'b0;
      end else if (wdog_q != '1) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end else begin
        wdog_d = wdog_q;
      end
    end
  end

  assign scan_code     = scan_code_q;
  assign is_break_code = is_break_q;
  assign is_extended   = is_ext_q;
  assign code_valid    = code_valid_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Scoreboard bench for ps2_rx_decoder: a host-side model predicts each strobe
// when a frame is driven; a monitor pops and compares as strobes appear.
module tb_ps2_rx_decoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       is_break_code;
  logic       is_extended;
  logic       code_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_rx_decoder #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .scan_code     (scan_code),
    .is_break_code (is_break_code),
    .is_extended   (is_extended),
    .code_valid    (code_valid),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_mis = 0;

  // Host-side model of prefix state and held outputs.
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] h_code = 8'h00;
  logic       h_brk = 1'b0, h_ext = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (code_valid || frame_err)) begin
      check_eq("strobe_excl", 32'(code_valid & frame_err), 32'd0);
      check_eq("strobe_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check_eq("strobe_kind_err", 32'(frame_err), 32'(mon_e.is_err));
        check_eq("scan_code", 32'(scan_code), 32'(mon_e.code));
        check_eq("is_break_code", 32'(is_break_code), 32'(mon_e.brk));
        check_eq("is_extended", 32'(is_extended), 32'(mon_e.ext));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.code = h_code; e.brk = h_brk; e.ext = h_ext;
    q.push_back(e);
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input int glitch_bit);
    logic [10:0] fr;
    exp_t        e;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (bad_par || bad_stop) begin
      push_err();
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      e.is_err = 1'b0; e.code = b; e.brk = m_brk; e.ext = m_ext;
      q.push_back(e);
      h_code = b; h_brk = m_brk; h_ext = m_ext;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    for (int i = 0; i < 11; i++) send_bit(fr[i], 1'(i == glitch_bit));
    ps2_data = 1'b1;
  endtask

  task automatic drained(input string tag);
    wait_cyc(4);
    check_eq(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_scan_code"}, 32'(scan_code), 32'd0);
    check_eq({tag, "_break"}, 32'(is_break_code), 32'd0);
    check_eq({tag, "_ext"}, 32'(is_extended), 32'd0);
    check_eq({tag, "_strobes"}, 32'({code_valid, frame_err}), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    check_zero_outputs("reset");

    // Plain make code
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    drained("make_1c");

    // Break sequence, back-to-back frames
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    drained("after_f0_no_strobe");
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    drained("break_1c");

    // Extended make, then extended break
    send_frame(8'hE0, 1'b0, 1'b0, -1);
    send_frame(8'h75, 1'b0, 1'b0, -1);
    drained("ext_75");
    send_frame(8'hE0, 1'b0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(8'h75, 1'b0, 1'b0, -1);
    drained("ext_break_75");

    // Parity error holds outputs; bad frame clears pending break
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    drained("parity_err");
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    drained("err_clears_break");

    // Bad stop bit
    send_frame(8'h2A, 1'b0, 1'b1, -1);
    drained("stop_err");
    send_frame(8'h2A, 1'b0, 1'b0, -1);
    drained("after_stop_err");

    // Timeout after start + 4 data bits, with a pending extended prefix
    send_frame(8'hE0, 1'b0, 1'b0, -1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    push_err();
    wait_cyc(TO + 100);
    drained("timeout");
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    drained("after_timeout");

    // Short ps2_clk glitch mid-frame must be ignored
    send_frame(8'h1C, 1'b0, 1'b0, 4);
    drained("glitch");

    // Reset mid-frame: silent drop, outputs cleared
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    m_brk = 1'b0; m_ext = 1'b0;
    h_code = 8'h00; h_brk = 1'b0; h_ext = 1'b0;
    wait_cyc(2);
    check_zero_outputs("mid_reset");
    wait_cyc(50);
    drained("mid_reset_no_err");
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    drained("after_mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
